// File: rtl/smart_meter_energy_sampler.sv
// -----------------------------------------------------------------------------
// smart_meter_energy_sampler
// Accumulates signed power samples into windows of 2^LOG2_WIN samples and
// reports the scaled positive (export) and negative (import) averages, with a
// sticky flag when a partial window is abandoned because samples stopped.
//
// Ports
//   clk_clk        in   1  clock, rising edge
//   reset_reset    in   1  synchronous active-high reset
//   enable         in   1  run control; low holds the block idle
//   sample_in      in  12  signed power sample (+ export, - import)
//   sample_valid   in   1  sample_in qualifier, one cycle per sample
//   data_pos_out   out  8  scaled average of positive power, last window
//   data_neg_out   out  8  scaled average of negative-power magnitude
//   data_valid_out out  1  one-cycle pulse when new averages are posted
//   sample_timeout out  1  sticky: a partial window was aborted on timeout
// -----------------------------------------------------------------------------
module smart_meter_energy_sampler #(
    parameter int unsigned LOG2_WIN  = 4,
    parameter int unsigned OUT_SHIFT = 3,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enable,
    input  logic [11:0] sample_in,
    input  logic        sample_valid,
    output logic [7:0]  data_pos_out,
    output logic [7:0]  data_neg_out,
    output logic        data_valid_out,
    output logic        sample_timeout
);

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned ACC_W    = SAMPLE_W + LOG2_WIN;
    localparam int unsigned CNT_W    = LOG2_WIN;
    localparam int unsigned GAP_W    = 16;
    localparam int unsigned WIN      = 1 << LOG2_WIN;
    localparam int unsigned SHIFT    = LOG2_WIN + OUT_SHIFT;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   pos_acc_q;
    logic [ACC_W-1:0]   neg_acc_q;
    logic [CNT_W-1:0]   count_q;
    logic [GAP_W-1:0]   gap_q;
    logic [7:0]         data_pos_q;
    logic [7:0]         data_neg_q;
    logic               data_valid_q;
    logic               timeout_q;

    logic               sample_is_pos;
    logic               sample_is_neg;
    logic [11:0]        sample_mag;
    logic [ACC_W-1:0]   pos_sum;
    logic [ACC_W-1:0]   neg_sum;
    logic [ACC_W-1:0]   pos_scaled;
    logic [ACC_W-1:0]   neg_scaled;
    logic [7:0]         pos_sat;
    logic [7:0]         neg_sat;
    logic               window_done;
    logic               timeout_hit;

    // Sample classification, window sums including the current sample, scaling
    always_comb begin
        sample_is_neg = sample_in[11];
        sample_is_pos = !sample_in[11] && (|sample_in);
        // -2048 negates to 12'h800, which read unsigned is the required 2048
        sample_mag    = sample_is_neg ? 12'(-sample_in) : sample_in;

        pos_sum = pos_acc_q + (sample_is_pos ? ACC_W'(sample_in)  : '0);
        neg_sum = neg_acc_q + (sample_is_neg ? ACC_W'(sample_mag) : '0);

        pos_scaled = pos_sum >> SHIFT;
        neg_scaled = neg_sum >> SHIFT;
        pos_sat    = (pos_scaled > ACC_W'(255)) ? 8'hFF : pos_scaled[7:0];
        neg_sat    = (neg_scaled > ACC_W'(255)) ? 8'hFF : neg_scaled[7:0];

        window_done = (count_q == CNT_W'(WIN - 1));
        timeout_hit = (gap_q == GAP_W'(TIMEOUT - 1));
    end

    // Control FSM plus accumulator, counter and output registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            pos_acc_q    <= '0;
            neg_acc_q    <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            data_pos_q   <= '0;
            data_neg_q   <= '0;
            data_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pos_acc_q <= '0;
                    neg_acc_q <= '0;
                    count_q   <= '0;
                    gap_q     <= '0;
                    timeout_q <= 1'b0;
                    if (enable) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!enable) begin
                        // Leaving: any partial window is dropped silently
                        state_q   <= IDLE;
                        pos_acc_q <= '0;
                        neg_acc_q <= '0;
                        count_q   <= '0;
                        gap_q     <= '0;
                        timeout_q <= 1'b0;
                    end else if (sample_valid) begin
                        gap_q <= '0;
                        if (window_done) begin
                            data_pos_q   <= pos_sat;
                            data_neg_q   <= neg_sat;
                            data_valid_q <= 1'b1;
                            pos_acc_q    <= '0;
                            neg_acc_q    <= '0;
                            count_q      <= '0;
                        end else begin
                            pos_acc_q <= pos_sum;
                            neg_acc_q <= neg_sum;
                            count_q   <= count_q + CNT_W'(1);
                        end
                    end else if (count_q != '0) begin
                        // Gap counting only runs inside a partial window
                        if (timeout_hit) begin
                            pos_acc_q <= '0;
                            neg_acc_q <= '0;
                            count_q   <= '0;
                            gap_q     <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_pos_out   = data_pos_q;
    assign data_neg_out   = data_neg_q;
    assign data_valid_out = data_valid_q;
    assign sample_timeout = timeout_q;

endmodule
